// File: rtl/dsi_lanes_distributor.sv
// Spreads assembler words byte-by-byte across 1-4 D-PHY data lanes and sequences the HS burst.
// Optional feature macro: DSI_LANES_DISTR_UNDERFLOW_CNT_EN adds the saturating underflow_cnt output.
module dsi_lanes_distributor (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] iface_write_data,
  input  logic [3:0]  iface_write_strb,
  input  logic        iface_write_rqst,
  input  logic        iface_last_word,
  output logic        iface_data_rqst,
  input  logic [1:0]  lanes_number,
  output logic        hs_request,
  input  logic        hs_ready,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_valid,
  output logic        underflow,
`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HS_RQST = 2'd1,
    ST_DATA    = 2'd2,
    ST_EOT     = 2'd3
  } state_t;

  // Illegal strobe patterns are treated as a full word.
  function automatic logic [2:0] strb_bytes(input logic [3:0] strb);
    case (strb)
      4'b0000: return 3'd0;
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b0111: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  n_r;
  logic [63:0] buf_r;
  logic [3:0]  count_r;
  logic        last_r;

  logic [3:0]  lanes_s;
  logic [2:0]  pop_s;
  logic [2:0]  push_s;
  logic        data_rqst_s;
  logic        xfer_s;
  logic        underflow_s;
  logic [31:0] push_data_s;
  logic [3:0]  wr_pos_s;
  logic [63:0] buf_next_s;
  logic [3:0]  count_next_s;

  // Buffer keeps bytes packed from byte 0 (oldest); bytes at or above count are always zero.
  always_comb begin
    lanes_s     = {2'b00, n_r} + 4'd1;
    pop_s       = 3'd0;
    underflow_s = 1'b0;
    if (state_r == ST_DATA) begin
      underflow_s = (count_r == 4'd0) && !last_r;
      if (hs_ready) begin
        pop_s = (count_r < lanes_s) ? count_r[2:0] : lanes_s[2:0];
      end else begin
        pop_s = 3'd0;
      end
    end else begin
      pop_s = 3'd0;
    end

    data_rqst_s  = ((state_r == ST_HS_RQST) || (state_r == ST_DATA)) &&
                   (count_r <= 4'd4) && !last_r;
    xfer_s       = iface_write_rqst && data_rqst_s;
    push_s       = xfer_s ? strb_bytes(iface_write_strb) : 3'd0;
    push_data_s  = iface_write_data & byte_mask(lane_mask(push_s));
    wr_pos_s     = count_r - {1'b0, pop_s};
    buf_next_s   = (buf_r >> {pop_s, 3'b000}) | ({32'h0000_0000, push_data_s} << {wr_pos_s, 3'b000});
    count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
  end

  assign iface_data_rqst = data_rqst_s;

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for the HS burst sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iface_write_rqst) state_next_s = ST_HS_RQST;
        else                  state_next_s = ST_IDLE;
      end
      ST_HS_RQST: begin
        if (hs_ready) state_next_s = ST_DATA;
        else          state_next_s = ST_HS_RQST;
      end
      ST_DATA: begin
        if (last_r && (count_r == {1'b0, pop_s})) state_next_s = ST_EOT;
        else                                      state_next_s = ST_DATA;
      end
      ST_EOT: begin
        if (!hs_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_EOT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Holding buffer, byte count, latched lane count and last-word flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      n_r     <= 2'd0;
      buf_r   <= 64'h0;
      count_r <= 4'd0;
      last_r  <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (iface_write_rqst) begin
        n_r     <= lanes_number;
        buf_r   <= 64'h0;
        count_r <= 4'd0;
        last_r  <= 1'b0;
      end
    end else begin
      buf_r   <= buf_next_s;
      count_r <= count_next_s;
      if (xfer_s && iface_last_word) last_r <= 1'b1;
    end
  end

  // Registered outputs: HS request, busy and the popped lane bytes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hs_request <= 1'b0;
      busy       <= 1'b0;
      lane_data  <= 32'h0;
      lane_valid <= 4'b0000;
      underflow  <= 1'b0;
    end else begin
      hs_request <= (state_next_s == ST_HS_RQST) || (state_next_s == ST_DATA);
      busy       <= (state_next_s != ST_IDLE);
      lane_data  <= buf_r[31:0] & byte_mask(lane_mask(pop_s));
      lane_valid <= lane_mask(pop_s);
      underflow  <= underflow_s;
    end
  end

`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
  // Saturating count of underflow pulses; only reset clears it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= 16'h0000;
    end else if (underflow_s && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Bench for dsi_lanes_distributor: byte-queue reference model compared every cycle, plus literal beat lists.
module tb_dsi_lanes_distributor;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst;
  logic        iface_last_word;
  logic        iface_data_rqst;
  logic [1:0]  lanes_number;
  logic        hs_request;
  logic        hs_ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic        underflow;
  logic        busy;
`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  dsi_lanes_distributor dut (
    .clk_sys          (clk_sys),
    .rst_n            (rst_n),
    .iface_write_data (iface_write_data),
    .iface_write_strb (iface_write_strb),
    .iface_write_rqst (iface_write_rqst),
    .iface_last_word  (iface_last_word),
    .iface_data_rqst  (iface_data_rqst),
    .lanes_number     (lanes_number),
    .hs_request       (hs_request),
    .hs_ready         (hs_ready),
    .lane_data        (lane_data),
    .lane_valid       (lane_valid),
    .underflow        (underflow),
`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
    .underflow_cnt    (underflow_cnt),
`endif
    .busy             (busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Reference model: burst phase (0 idle, 1 request, 2 data, 3 eot) and a byte queue.
  int          m_phase;
  logic [7:0]  m_q[$];
  int          m_n;
  bit          m_last;
  bit          m_xfer;
  int          m_nbeats;
  logic [31:0] e_data;
  logic [3:0]  e_valid;
  bit          e_under, e_hsreq, e_busy;
  int          e_ucnt;

  logic [31:0] w_data[$];
  logic [3:0]  w_strb[$];
  logic        w_last[$];
  logic [35:0] d_beats[$];
  logic [35:0] exp_beats[$];
  int          xfer_cyc[$];
  int          d_uf;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int legal_bytes(input logic [3:0] s);
    case (s)
      4'b0000: return 0;
      4'b0001: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] v);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{v[i]}};
    return r;
  endfunction

  function automatic logic m_rqst();
    return ((m_phase == 1) || (m_phase == 2)) && ((8 - m_q.size()) >= 4) && !m_last;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_n = 1; m_last = 1'b0; m_xfer = 1'b0;
    e_data = 32'h0; e_valid = 4'h0; e_under = 1'b0; e_hsreq = 1'b0; e_busy = 1'b0; e_ucnt = 0;
  endtask

  task automatic model_step();
    logic rq;
    logic xfer;
    int   p;
    int   nb;
    rq = m_rqst();
    xfer = iface_write_rqst && rq;
    p = 0;
    e_data = 32'h0; e_valid = 4'h0; e_under = 1'b0;
    case (m_phase)
      0: if (iface_write_rqst) begin
        m_phase = 1; m_n = int'(lanes_number) + 1; m_q.delete(); m_last = 1'b0;
      end
      1: if (hs_ready) m_phase = 2;
      2: begin
        if (m_q.size() == 0 && !m_last) e_under = 1'b1;
        if (hs_ready) p = (m_q.size() < m_n) ? m_q.size() : m_n;
        for (int j = 0; j < p; j++) begin
          e_data[8*j +: 8] = m_q.pop_front();
          e_valid[j] = 1'b1;
        end
        if (m_last && m_q.size() == 0) m_phase = 3;
      end
      default: if (!hs_ready) m_phase = 0;
    endcase
    if (xfer) begin
      nb = legal_bytes(iface_write_strb);
      for (int k = 0; k < nb; k++) m_q.push_back(iface_write_data[8*k +: 8]);
      if (iface_last_word) m_last = 1'b1;
    end
    e_hsreq = (m_phase == 1) || (m_phase == 2);
    e_busy  = (m_phase != 0);
    if (e_under && e_ucnt < 65535) e_ucnt++;
    if (e_valid != 4'h0) m_nbeats++;
    m_xfer = xfer;
  endtask

  // Compare DUT against the model away from the active edge, and log observed beats/transfers.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("data_rqst",  36'(iface_data_rqst), 36'(m_rqst()));
      check("hs_request", 36'(hs_request), 36'(e_hsreq));
      check("busy",       36'(busy), 36'(e_busy));
      check("lane_valid", 36'(lane_valid), 36'(e_valid));
      check("lane_data",  36'(lane_data & bmask(e_valid)), 36'(e_data));
      check("underflow",  36'(underflow), 36'(e_under));
`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
      check("underflow_cnt", 36'(underflow_cnt), 36'(e_ucnt));
`endif
      if (lane_valid != 4'h0) d_beats.push_back({lane_valid, lane_data & bmask(lane_valid)});
      if (underflow) d_uf++;
      if (iface_write_rqst && iface_data_rqst) xfer_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    if (rst_n) model_step();
    cyc++;
    #1;
  endtask

  task automatic add_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    w_data.push_back(d); w_strb.push_back(s); w_last.push_back(l);
  endtask

  task automatic clear_words();
    w_data.delete(); w_strb.delete(); w_last.delete();
  endtask

  // Source + PHY stub for one burst; stalls count only cycles where the block would accept.
  task automatic run_burst(input logic [1:0] ln, input int delay, input int stall_at,
                           input int stall_len, input int abort_at);
    int widx, stall_left, ticks, rq_cnt;
    bit done;
    widx = 0; stall_left = 0; ticks = 0; rq_cnt = 0; done = 1'b0;
    d_beats.delete(); xfer_cyc.delete(); m_nbeats = 0; d_uf = 0;
    lanes_number = ln;
    while (!done && ticks < 300) begin
      if (widx >= w_data.size()) begin
        iface_write_rqst = 1'b0;
      end else if (stall_left > 0 && m_rqst()) begin
        iface_write_rqst = 1'b0;
        stall_left--;
      end else begin
        iface_write_rqst = 1'b1;
        iface_write_data = w_data[widx];
        iface_write_strb = w_strb[widx];
        iface_last_word  = w_last[widx];
      end
      tick();
      ticks++;
      if (ticks == 1) lanes_number = ~ln;
      if (m_xfer) begin
        widx++;
        if (widx == stall_at) stall_left = stall_len;
      end
      if (m_phase == 1) begin
        rq_cnt++;
        if (rq_cnt >= delay) hs_ready = 1'b1;
      end else if (m_phase != 2) begin
        hs_ready = 1'b0;
      end
      if ((abort_at != 0 && ticks == abort_at) || m_phase == 0) done = 1'b1;
    end
    iface_write_rqst = 1'b0;
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL burst_timeout: burst still running after %0d cycles, want completion", ticks);
    end
  endtask

  task automatic check_beats(input string name);
    int n;
    check({name, "_dut_beats"},   36'(d_beats.size()), 36'(exp_beats.size()));
    check({name, "_model_beats"}, 36'(m_nbeats), 36'(exp_beats.size()));
    n = (d_beats.size() < exp_beats.size()) ? d_beats.size() : exp_beats.size();
    for (int i = 0; i < n; i++) check({name, "_beat"}, d_beats[i], exp_beats[i]);
  endtask

  initial begin
    rst_n = 1'b0; iface_write_data = 32'h0; iface_write_strb = 4'h0; iface_write_rqst = 1'b0;
    iface_last_word = 1'b0; lanes_number = 2'd0; hs_ready = 1'b0;
    model_reset();
    #2;
    check("rst_data_rqst",  36'(iface_data_rqst), 36'h0);
    check("rst_hs_request", 36'(hs_request), 36'h0);
    check("rst_lane_data",  36'(lane_data), 36'h0);
    check("rst_lane_valid", 36'(lane_valid), 36'h0);
    check("rst_underflow",  36'(underflow), 36'h0);
    check("rst_busy",       36'(busy), 36'h0);
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // 4 lanes, three full words.
    clear_words();
    add_word(32'h03020100, 4'hF, 1'b0);
    add_word(32'h07060504, 4'hF, 1'b0);
    add_word(32'h0B0A0908, 4'hF, 1'b1);
    run_burst(2'd3, 2, -1, 0, 0);
    exp_beats = '{36'hF_03020100, 36'hF_07060504, 36'hF_0B0A0908};
    check_beats("four_lanes");
    tick();

    // 2 lanes, full word then a single trailing byte.
    clear_words();
    add_word(32'h03020100, 4'hF, 1'b0);
    add_word(32'h00000004, 4'h1, 1'b1);
    run_burst(2'd1, 2, -1, 0, 0);
    exp_beats = '{36'h3_00000100, 36'h3_00000302, 36'h1_00000004};
    check_beats("two_lanes");
    tick();

    // 1 lane, 4-byte packet.
    clear_words();
    add_word(32'h13121110, 4'hF, 1'b1);
    run_burst(2'd0, 2, -1, 0, 0);
    exp_beats = '{36'h1_00000010, 36'h1_00000011, 36'h1_00000012, 36'h1_00000013};
    check_beats("one_lane");
    tick();

    // 1 lane, 16 bytes: steady-state word spacing must be 4 cycles.
    clear_words();
    add_word(32'h23222120, 4'hF, 1'b0);
    add_word(32'h27262524, 4'hF, 1'b0);
    add_word(32'h2B2A2928, 4'hF, 1'b0);
    add_word(32'h2F2E2D2C, 4'hF, 1'b1);
    run_burst(2'd0, 2, -1, 0, 0);
    exp_beats.delete();
    for (int i = 0; i < 16; i++) exp_beats.push_back({4'h1, 24'h0, 8'(8'h20 + i)});
    check_beats("one_lane_long");
    check("one_lane_xfers", 36'(xfer_cyc.size()), 36'd4);
    if (xfer_cyc.size() == 4) check("one_lane_spacing", 36'(xfer_cyc[3] - xfer_cyc[2]), 36'd4);
    tick();

    // 3 lanes, source stalls 3 cycles once the buffer can accept again.
    clear_words();
    add_word(32'h03020100, 4'hF, 1'b0);
    add_word(32'h07060504, 4'hF, 1'b0);
    add_word(32'h0B0A0908, 4'hF, 1'b1);
    run_burst(2'd2, 2, 2, 3, 0);
    exp_beats = '{36'h7_00020100, 36'h7_00050403, 36'h3_00000706, 36'h7_000A0908, 36'h1_0000000B};
    check_beats("three_lanes_stall");
    check("stall_underflows", 36'(d_uf), 36'd3);
`ifdef DSI_LANES_DISTR_UNDERFLOW_CNT_EN
    check("stall_underflow_cnt", 36'(underflow_cnt), 36'd3);
`endif
    tick();

    // Empty last word after 8 buffered bytes.
    clear_words();
    add_word(32'h03020100, 4'hF, 1'b0);
    add_word(32'h07060504, 4'hF, 1'b0);
    add_word(32'h00000000, 4'h0, 1'b1);
    run_burst(2'd3, 2, -1, 0, 0);
    exp_beats = '{36'hF_03020100, 36'hF_07060504};
    check_beats("empty_last");
    tick();

    // Reset asserted mid-burst, then a fresh 2-lane burst.
    clear_words();
    add_word(32'h03020100, 4'hF, 1'b0);
    add_word(32'h07060504, 4'hF, 1'b0);
    add_word(32'h0B0A0908, 4'hF, 1'b1);
    run_burst(2'd3, 2, -1, 0, 4);
    check("pre_reset_busy", 36'(busy), 36'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    hs_ready = 1'b0;
    #1;
    check("arst_data_rqst",  36'(iface_data_rqst), 36'h0);
    check("arst_hs_request", 36'(hs_request), 36'h0);
    check("arst_lane_data",  36'(lane_data), 36'h0);
    check("arst_lane_valid", 36'(lane_valid), 36'h0);
    check("arst_underflow",  36'(underflow), 36'h0);
    check("arst_busy",       36'(busy), 36'h0);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    tick();
    clear_words();
    add_word(32'hA3A2A1A0, 4'hF, 1'b1);
    run_burst(2'd1, 2, -1, 0, 0);
    exp_beats = '{36'h3_0000A1A0, 36'h3_0000A3A2};
    check_beats("after_reset");
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
